reflector_prog: RTL and testbench

Programmable, parametrised reflector for the Enigma datapath, supporting rewirable-reflector (UKW-D style) configurations. It holds two banks of pairing tables. One bank is active and serves single-cycle registered lookups. The other is a shadow bank, loaded pair-by-pair over a valid/ready interface, validated, and then swapped in atomically. It sits between the last rotor's forward output and the same rotor's reverse input.

---
 rtl/reflector_pkg.sv | 69 ++++++
 rtl/reflector_bank.sv | 57 +++++
 rtl/reflector_prog.sv | 202 ++++++++++++++++++++
 tb/tb_reflector_prog.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflector_pkg.sv
// reflector_pkg: shared definitions for the programmable reflector.
//   - symbol constants SYM_A..SYM_Z (0..25)
//   - state_e: configuration FSM states
//   - ukw_b(idx): historical wiring B partner of a symbol
//   - default_pair(idx, n): reset-time partner for an n-symbol alphabet
package reflector_pkg;

   localparam int SYM_A = 0;
   localparam int SYM_B = 1;
   localparam int SYM_C = 2;
   localparam int SYM_D = 3;
   localparam int SYM_E = 4;
   localparam int SYM_F = 5;
   localparam int SYM_G = 6;
   localparam int SYM_H = 7;
   localparam int SYM_I = 8;
   localparam int SYM_J = 9;
   localparam int SYM_K = 10;
   localparam int SYM_L = 11;
   localparam int SYM_M = 12;
   localparam int SYM_N = 13;
   localparam int SYM_O = 14;
   localparam int SYM_P = 15;
   localparam int SYM_Q = 16;
   localparam int SYM_R = 17;
   localparam int SYM_S = 18;
   localparam int SYM_T = 19;
   localparam int SYM_U = 20;
   localparam int SYM_V = 21;
   localparam int SYM_W = 22;
   localparam int SYM_X = 23;
   localparam int SYM_Y = 24;
   localparam int SYM_Z = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_CHECK = 2'd3
   } state_e;

   // Wiring B, listed in both directions so any index resolves directly.
   function automatic int ukw_b(input int idx);
      case (idx)
         SYM_A: return SYM_Y;   SYM_Y: return SYM_A;
         SYM_B: return SYM_R;   SYM_R: return SYM_B;
         SYM_C: return SYM_U;   SYM_U: return SYM_C;
         SYM_D: return SYM_H;   SYM_H: return SYM_D;
         SYM_E: return SYM_Q;   SYM_Q: return SYM_E;
         SYM_F: return SYM_S;   SYM_S: return SYM_F;
         SYM_G: return SYM_L;   SYM_L: return SYM_G;
         SYM_I: return SYM_P;   SYM_P: return SYM_I;
         SYM_J: return SYM_X;   SYM_X: return SYM_J;
         SYM_K: return SYM_N;   SYM_N: return SYM_K;
         SYM_M: return SYM_O;   SYM_O: return SYM_M;
         SYM_T: return SYM_Z;   SYM_Z: return SYM_T;
         SYM_V: return SYM_W;   SYM_W: return SYM_V;
         default: return idx;
      endcase
   endfunction

   // Only the 26-symbol alphabet has a historical wiring; other sizes
   // fall back to neighbour swapping, which is a valid involution for even n.
   function automatic int default_pair(input int idx, input int n);
      if (n == 26) return ukw_b(idx);
      return idx ^ 1;
   endfunction

endpackage

// File: rtl/reflector_bank.sv
// reflector_bank: one pairing table plus its used-bit vector.
//   clk, reset          : clock, synchronous active-high reset (loads default)
//   wr_en_i/wr_a_i/wr_b_i: write table[a]=b and table[b]=a, set both used bits
//   clr_en_i/clr_idx_i  : clear one used bit
//   rd_idx_i/rd_sym_o   : combinational table read (0 when index out of range)
//   used_o              : used-bit vector
// Callers guarantee write/clear indices are in range.
module reflector_bank
   import reflector_pkg::*;
#(
   parameter int N_SYMBOLS = 26,
   parameter int SYM_W     = $clog2(N_SYMBOLS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en_i,
   input  logic [SYM_W-1:0]     wr_a_i,
   input  logic [SYM_W-1:0]     wr_b_i,
   input  logic                 clr_en_i,
   input  logic [SYM_W-1:0]     clr_idx_i,
   input  logic [SYM_W-1:0]     rd_idx_i,
   output logic [SYM_W-1:0]     rd_sym_o,
   output logic [N_SYMBOLS-1:0] used_o
);

   logic [SYM_W-1:0]     tbl_q [N_SYMBOLS];
   logic [N_SYMBOLS-1:0] used_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_SYMBOLS; i++) begin
            tbl_q[i] <= SYM_W'(default_pair(i, N_SYMBOLS));
         end
         used_q <= '0;
      end else begin
         if (wr_en_i) begin
            tbl_q[wr_a_i]  <= wr_b_i;
            tbl_q[wr_b_i]  <= wr_a_i;
            used_q[wr_a_i] <= 1'b1;
            used_q[wr_b_i] <= 1'b1;
         end
         if (clr_en_i) begin
            used_q[clr_idx_i] <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_sym_o = '0;
      if (int'(rd_idx_i) < N_SYMBOLS) begin
         rd_sym_o = tbl_q[rd_idx_i];
      end
   end

   assign used_o = used_q;

endmodule

// File: rtl/reflector_prog.sv
// reflector_prog: programmable double-banked reflector.
//   Lookup : in_valid/in_sym -> out_valid/out_sym/out_err, 1-cycle latency,
//            no backpressure.
//   Config : cfg_start begins a shadow load (CLEAR then LOAD), pairs are
//            offered on cfg_valid/cfg_a/cfg_b, cfg_commit validates and swaps.
//            Status: busy, cfg_done (1-cycle pulse), cfg_err (sticky).
//   Debug  : dbg_state exposes the FSM state register.
// Handshake: a pair transfers on a rising edge where cfg_valid && cfg_ready;
// cfg_ready depends only on the FSM state (high throughout LOAD), never on
// cfg_valid, so the offerer may hold a pair steady until it is taken.
module reflector_prog
   import reflector_pkg::*;
#(
   parameter int N_SYMBOLS = 26,
   parameter int SYM_W     = $clog2(N_SYMBOLS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [SYM_W-1:0] in_sym,
   output logic             out_valid,
   output logic [SYM_W-1:0] out_sym,
   output logic             out_err,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [SYM_W-1:0] cfg_a,
   input  logic [SYM_W-1:0] cfg_b,
   input  logic             cfg_commit,
   output logic             busy,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic [1:0]       dbg_state
);

   localparam int PC_W = $clog2(N_SYMBOLS/2 + 1);

   state_e           state_q, state_d;
   logic [SYM_W-1:0] clr_idx_q, clr_idx_d;
   logic [PC_W-1:0]  pair_cnt_q, pair_cnt_d;
   logic             cfg_err_q, cfg_err_d;
   logic             sel_q, sel_d;        // index of the active bank
   logic             cfg_done_q, cfg_done_d;

   logic             out_valid_q, out_err_q;
   logic [SYM_W-1:0] out_sym_q;

   logic             sh_wr_en, sh_clr_en;
   logic [SYM_W-1:0] rd_sym0, rd_sym1, active_sym;
   logic [N_SYMBOLS-1:0] used0, used1, used_sh;

   logic a_in_range, b_in_range, in_in_range;
   logic used_a, used_b, pair_ok;

   // ---------------- banks ----------------
   // The shadow bank is whichever one sel_q does not point at.
   reflector_bank #(.N_SYMBOLS(N_SYMBOLS), .SYM_W(SYM_W)) u_bank0 (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (sh_wr_en & sel_q),
      .wr_a_i    (cfg_a),
      .wr_b_i    (cfg_b),
      .clr_en_i  (sh_clr_en & sel_q),
      .clr_idx_i (clr_idx_q),
      .rd_idx_i  (in_sym),
      .rd_sym_o  (rd_sym0),
      .used_o    (used0)
   );

   reflector_bank #(.N_SYMBOLS(N_SYMBOLS), .SYM_W(SYM_W)) u_bank1 (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (sh_wr_en & ~sel_q),
      .wr_a_i    (cfg_a),
      .wr_b_i    (cfg_b),
      .clr_en_i  (sh_clr_en & ~sel_q),
      .clr_idx_i (clr_idx_q),
      .rd_idx_i  (in_sym),
      .rd_sym_o  (rd_sym1),
      .used_o    (used1)
   );

   assign active_sym = sel_q ? rd_sym1 : rd_sym0;
   assign used_sh    = sel_q ? used0   : used1;

   // ---------------- pair checks ----------------
   assign a_in_range  = int'(cfg_a)  < N_SYMBOLS;
   assign b_in_range  = int'(cfg_b)  < N_SYMBOLS;
   assign in_in_range = int'(in_sym) < N_SYMBOLS;

   // Used bits are only looked up for in-range symbols.
   assign used_a  = a_in_range ? used_sh[cfg_a] : 1'b0;
   assign used_b  = b_in_range ? used_sh[cfg_b] : 1'b0;
   assign pair_ok = a_in_range && b_in_range && (cfg_a != cfg_b) && !used_a && !used_b;

   // ---------------- FSM ----------------
   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      pair_cnt_d = pair_cnt_q;
      cfg_err_d  = cfg_err_q;
      sel_d      = sel_q;
      cfg_done_d = 1'b0;
      sh_wr_en   = 1'b0;
      sh_clr_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d    = ST_CLEAR;
               clr_idx_d  = '0;
               pair_cnt_d = '0;
               cfg_err_d  = 1'b0;
            end
         end
         ST_CLEAR: begin
            sh_clr_en  = 1'b1;
            clr_idx_d  = clr_idx_q + SYM_W'(1);
            pair_cnt_d = '0;
            cfg_err_d  = 1'b0;
            if (clr_idx_q == SYM_W'(N_SYMBOLS - 1)) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               // Restart wins over any pair or commit in the same cycle.
               state_d    = ST_CLEAR;
               clr_idx_d  = '0;
               pair_cnt_d = '0;
               cfg_err_d  = 1'b0;
            end else begin
               if (cfg_valid) begin
                  if (pair_ok) begin
                     sh_wr_en   = 1'b1;
                     pair_cnt_d = pair_cnt_q + PC_W'(1);
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
               // A same-cycle pair lands in pair_cnt/cfg_err before CHECK reads them.
               if (cfg_commit) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            cfg_done_d = 1'b1;
            state_d    = ST_IDLE;
            if (!cfg_err_q && (pair_cnt_q == PC_W'(N_SYMBOLS/2))) begin
               sel_d = ~sel_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         clr_idx_q  <= '0;
         pair_cnt_q <= '0;
         cfg_err_q  <= 1'b0;
         sel_q      <= 1'b0;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         pair_cnt_q <= pair_cnt_d;
         cfg_err_q  <= cfg_err_d;
         sel_q      <= sel_d;
         cfg_done_q <= cfg_done_d;
      end
   end

   // ---------------- lookup register ----------------
   // Reads through the currently selected bank, so a swap takes effect for
   // lookups sampled on the edge after sel_q changes.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         out_err_q   <= in_valid && !in_in_range;
         if (in_valid) begin
            out_sym_q <= in_in_range ? active_sym : in_sym;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_err   = out_err_q;
   assign cfg_ready = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_IDLE);
   assign cfg_done  = cfg_done_q;
   assign cfg_err   = cfg_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_reflector_prog.sv
module tb_reflector_prog;

  localparam int N = 26;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_sym;
  logic         out_valid;
  logic [W-1:0] out_sym;
  logic         out_err;
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_a;
  logic [W-1:0] cfg_b;
  logic         cfg_commit;
  logic         busy;
  logic         cfg_done;
  logic         cfg_err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  // scoreboard queues: {err, sym} per lookup, expected cfg_err per cfg_done
  logic [W:0] exp_q[$];
  logic       done_q[$];

  // bench model of the active table
  int model[N];
  int wiring_b[N] = '{24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
                      10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19};

  reflector_prog #(.N_SYMBOLS(N), .SYM_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sym     (in_sym),
    .out_valid  (out_valid),
    .out_sym    (out_sym),
    .out_err    (out_err),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_commit (cfg_commit),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic lookup(input int s);
    in_valid = 1'b1;
    in_sym   = W'(s);
    if (s < N) exp_q.push_back({1'b0, W'(model[s])});
    else       exp_q.push_back({1'b1, W'(s)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    int c;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    c = 0;
    while (!cfg_ready && c < 100) begin
      tick();
      c++;
    end
    check("clear_cycles", c, N);
    check("err_cleared", cfg_err, 0);
  endtask

  task automatic send_pair(input int a, input int b);
    int c;
    cfg_valid = 1'b1;
    cfg_a     = W'(a);
    cfg_b     = W'(b);
    c = 0;
    while (!cfg_ready && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) check("pair_ready_timeout", 0, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit(input logic exp_err);
    cfg_commit = 1'b1;
    done_q.push_back(exp_err);
    tick();
    cfg_commit = 1'b0;
    check("done_early", cfg_done, 0);
    check("busy_in_check", busy, 1);
    tick();
    check("done_pulse", cfg_done, 1);
    check("busy_after_done", busy, 0);
    tick();
    check("done_one_cycle", cfg_done, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL lookup_unexpected: got err=%0d sym=%0d expected no output", out_err, out_sym);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("lookup", int'({out_err, out_sym}), int'(e));
      end
    end
    if (!reset && cfg_done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL done_unexpected: got cfg_done=1 expected 0");
      end else begin
        logic e;
        e = done_q.pop_front();
        check("done_cfg_err", int'(cfg_err), int'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sym = '0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_a = '0; cfg_b = '0; cfg_commit = 1'b0;
    for (int i = 0; i < N; i++) model[i] = wiring_b[i];
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_err", cfg_err, 0);

    // single lookup latency: A -> Y one cycle later
    in_valid = 1'b1; in_sym = 0;
    exp_q.push_back({1'b0, W'(24)});
    tick();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_sym", out_sym, 24);
    tick();
    check("lat_valid_drop", out_valid, 0);

    // full sweep of wiring B plus out-of-range symbols, back to back
    for (int s = 0; s < N; s++) lookup(s);
    lookup(27);
    lookup(31);
    tick();

    // duplicate symbol: A-B then A-C
    start_load();
    send_pair(0, 1);
    check("dup_first_ok", cfg_err, 0);
    send_pair(0, 2);
    check("dup_second_err", cfg_err, 1);
    commit(1'b1);
    lookup(0);
    lookup(1);

    // only 12 pairs: clean but incomplete, table unchanged
    start_load();
    for (int i = 0; i < 12; i++) send_pair(2*i, 2*i+1);
    check("short_no_err", cfg_err, 0);
    commit(1'b0);
    lookup(0);
    lookup(25);

    // self pair E-E rejected
    start_load();
    send_pair(4, 4);
    check("self_pair_err", cfg_err, 1);
    // out-of-range partner rejected (restart abandons the previous load)
    start_load();
    send_pair(26, 3);
    check("range_pair_err", cfg_err, 1);

    // full load A-B .. Y-Z with continuous lookups of A across the commit
    start_load();
    for (int i = 0; i < 13; i++) send_pair(2*i, 2*i+1);
    check("full_no_err", cfg_err, 0);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_sym   = 0;
      exp_q.push_back({1'b0, W'(k <= 1 ? 24 : 1)});
      if (k == 0) begin
        cfg_commit = 1'b1;
        done_q.push_back(1'b0);
      end
      tick();
      cfg_commit = 1'b0;
      if (k == 0) check("swap_done_early", cfg_done, 0);
      if (k == 1) check("swap_done_pulse", cfg_done, 1);
      if (k == 1) check("swap_busy_fall", busy, 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) model[i] = i ^ 1;
    lookup(0);
    lookup(25);
    lookup(13);
    lookup(30);

    // reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) send_pair(i, 25 - i);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = wiring_b[i];
    check("midrst_busy", busy, 0);
    check("midrst_cfg_ready", cfg_ready, 0);
    check("midrst_cfg_err", cfg_err, 0);
    lookup(0);
    lookup(25);

    // normal load after reset: mirror pairing i <-> 25-i
    start_load();
    for (int i = 0; i < 13; i++) send_pair(i, 25 - i);
    commit(1'b0);
    for (int i = 0; i < N; i++) model[i] = 25 - i;
    lookup(0);
    lookup(12);
    lookup(25);

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
